// File: rtl/simon_pkg.sv
// Shared types, default timings and the RAND fold helper for the Simon game engine.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXTEND,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_PAUSE,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam int DEF_SHOW_CYCLES    = 25_000_000;
  localparam int DEF_GAP_CYCLES     = 12_500_000;
  localparam int DEF_TIMEOUT_CYCLES = 150_000_000;

  // RAND is always below 2*n, so one conditional subtraction maps it into range.
  function automatic int unsigned fold_rand(input int unsigned r, input int unsigned n);
    return (r >= n) ? r - n : r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable down-counter shared by every timed game phase; load wins over counting,
// and done is high in an enabled cycle once the count has reached zero.
module simon_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/simon_core.sv
// Parametrised Simon game engine: grows, plays back and checks a button sequence, tracks best score.
// Optional per-press input timeout is built only when SIMON_TIMEOUT_EN is defined.
module simon_core
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEPTH          = 16,
  parameter int SHOW_CYCLES    = DEF_SHOW_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [$clog2(NUM_BUTTONS)-1:0] IN,
  input  logic                           IN_VALID,
  input  logic [$clog2(NUM_BUTTONS)-1:0] RAND,
  output logic [$clog2(NUM_BUTTONS)-1:0] OUT,
  output logic                           OUT_ENA,
  output logic                           WIN,
  output logic                           LOSE,
  output logic                           HS,
  output logic [$clog2(DEPTH+1)-1:0]     LEVEL,
  output logic [$clog2(DEPTH+1)-1:0]     BEST,
  output logic                           BUSY
);

  localparam int BTN_W = $clog2(NUM_BUTTONS);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SIMON_TIMEOUT_EN
  localparam int MAX_CNT = max2(max2(SHOW_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int MAX_CNT = max2(SHOW_CYCLES, GAP_CYCLES);
`endif
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] WAIT_LD = '0;
`endif

  if (NUM_BUTTONS < 2 || DEPTH < 1 || SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("simon_core: illegal parameter value");
  end

  state_t             state, state_n;
  logic [LVL_W-1:0]   level, level_n;
  logic [LVL_W-1:0]   idx, idx_n, idx_inc;
  logic [LVL_W-1:0]   best, score;
  logic               hs, hs_clr, score_vld;
  logic               mem_wr;
  logic               t_load, t_en, t_done;
  logic [CNT_W-1:0]   t_val;
  logic [BTN_W-1:0]   mem [DEPTH];
  logic [BTN_W-1:0]   cur_btn, rand_fold;
  logic               in_ok;

  assign idx_inc   = idx + LVL_W'(1);
  assign cur_btn   = mem[idx[IDX_W-1:0]];
  assign rand_fold = BTN_W'(fold_rand(32'(RAND), NUM_BUTTONS));

  // With a power-of-two button count every encoding is a real button.
  if (NUM_BUTTONS == (1 << BTN_W)) begin : g_in_full
    assign in_ok = 1'b1;
  end else begin : g_in_part
    assign in_ok = (IN < BTN_W'(NUM_BUTTONS));
  end

`ifdef SIMON_TIMEOUT_EN
  assign t_en = (state == ST_SHOW_ON) || (state == ST_SHOW_OFF) ||
                (state == ST_PAUSE) || (state == ST_WAIT_IN);
`else
  assign t_en = (state == ST_SHOW_ON) || (state == ST_SHOW_OFF) || (state == ST_PAUSE);
`endif

  simon_tick_timer #(.W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  always_comb begin
    state_n   = state;
    level_n   = level;
    idx_n     = idx;
    t_load    = 1'b0;
    t_val     = '0;
    mem_wr    = 1'b0;
    hs_clr    = 1'b0;
    score_vld = 1'b0;
    score     = '0;
    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (START) begin
          state_n = ST_EXTEND;
          level_n = '0;
          hs_clr  = 1'b1;
        end
      end
      ST_EXTEND: begin
        mem_wr  = 1'b1;
        level_n = level + LVL_W'(1);
        idx_n   = '0;
        state_n = ST_SHOW_ON;
        t_load  = 1'b1;
        t_val   = SHOW_LD;
      end
      ST_SHOW_ON: begin
        if (t_done) begin
          state_n = ST_SHOW_OFF;
          t_load  = 1'b1;
          t_val   = GAP_LD;
        end
      end
      ST_SHOW_OFF: begin
        if (t_done) begin
          t_load = 1'b1;
          if (idx_inc == level) begin
            idx_n   = '0;
            state_n = ST_WAIT_IN;
            t_val   = WAIT_LD;
          end else begin
            idx_n   = idx_inc;
            state_n = ST_SHOW_ON;
            t_val   = SHOW_LD;
          end
        end
      end
      ST_WAIT_IN: begin
        if (IN_VALID && in_ok) begin
          if (IN == cur_btn) begin
            if (idx_inc == level) begin
              if (level == LVL_W'(DEPTH)) begin
                state_n   = ST_WIN;
                score_vld = 1'b1;
                score     = LVL_W'(DEPTH);
              end else begin
                state_n = ST_PAUSE;
                t_load  = 1'b1;
                t_val   = GAP_LD;
              end
            end else begin
              idx_n  = idx_inc;
              t_load = 1'b1;
              t_val  = WAIT_LD;
            end
          end else begin
            state_n   = ST_LOSE;
            score_vld = 1'b1;
            score     = level - LVL_W'(1);
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (t_done) begin
          state_n   = ST_LOSE;
          score_vld = 1'b1;
          score     = level - LVL_W'(1);
        end
`endif
      end
      ST_PAUSE: begin
        if (t_done) begin
          state_n = ST_EXTEND;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      level <= '0;
      idx   <= '0;
      best  <= '0;
      hs    <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      idx   <= idx_n;
      if (hs_clr) begin
        hs <= 1'b0;
      end else if (score_vld && (score > best)) begin
        best <= score;
        hs   <= 1'b1;
      end
    end
  end

  // Sequence storage needs no reset: entries are always written before they are read.
  always_ff @(posedge CLK) begin
    if (mem_wr) begin
      mem[level[IDX_W-1:0]] <= rand_fold;
    end
  end

  assign OUT_ENA = (state == ST_SHOW_ON);
  assign OUT     = OUT_ENA ? cur_btn : '0;
  assign WIN     = (state == ST_WIN);
  assign LOSE    = (state == ST_LOSE);
  assign BUSY    = !((state == ST_IDLE) || (state == ST_WIN) || (state == ST_LOSE));
  assign HS      = hs;
  assign LEVEL   = level;
  assign BEST    = best;

endmodule
